seg7_scan_ctrl: RTL and testbench
=================================

# seg7_scan_ctrl

Parametrised time-multiplexed seven-segment display controller. It scans `DIGITS` hex digits one at a time onto a shared segment bus, and drives the digit enables and the decimal point. Compared with the existing fixed 4-digit scanner it adds:
- tear-free frame snapshot of the input value,
- anti-ghosting dead time at the start of each slot,
- per-digit blanking and blinking,
- leading-zero suppression,
- selectable output polarity.

It sits between the password/value datapath and the board display pins.

## Interface

- `DIGITS`, 4, number of digits scanned (1..8).
- `SCAN_DIV`, 50000, clk cycles per digit slot (≥ 2).
- `BLANK_CYC`, 16, dead-time cycles at the start of each slot (0 ≤ BLANK_CYC < SCAN_DIV).
- `BLINK_FRAMES`, 64, full frames per blink half-period (≥ 1).
- `SEG_ACTIVE_HIGH`, 1, 1 = lit segment/dp driven 1; 0 = driven 0.
- `DIG_ACTIVE_HIGH`, 1, 1 = enabled digit driven 1; 0 = driven 0.

Ports (reset rst, asynchronous, active-low; clock clk):
- `clk` in 1 system clock.
- `rst` in 1 asynchronous active-low reset.
- `value` in 4*DIGITS packed nibbles; digit i = value[4i+3:4i]; digit 0 is least significant.
- `dp_in` in DIGITS per-digit decimal point request.
- `blank_mask` in DIGITS 1 = digit always dark.
- `blink_mask` in DIGITS 1 = digit dark during the blink-off phase.
- `lz_en` in 1 enable leading-zero suppression.
- `dig` out DIGITS one-hot digit enable (polarity per DIG_ACTIVE_HIGH).
- `seg` out 7 segments a..g, where bit6 = a and bit0 = g (polarity per SEG_ACTIVE_HIGH).
- `dp` out 1 decimal point (polarity per SEG_ACTIVE_HIGH).
- `frame_start` out 1 one-cycle pulse on the cycle after the snapshot is taken.

## Operation

**Counters**
- Slot counter `cnt` counts 0..SCAN_DIV-1 and wraps to 0.
- Digit index `idx` advances on a wrap of `cnt`, going from DIGITS-1 back to 0.

**Snapshot**
- On the cycle where cnt = SCAN_DIV-1 and idx = DIGITS-1, the shadow registers load `value`, `dp_in`, `blank_mask`, `blink_mask` and `lz_en`.
- Input changes at any other time have no visible effect until the next snapshot.

**Blink**
- A frame counter increments at each snapshot.
- When it reaches BLINK_FRAMES-1 it resets to 0 and `blink_phase` toggles.
- blink_phase = 1 is the off phase.

**Leading-zero suppression**
- With shadow lz_en = 1, digit i (i ≥ 1) is suppressed when shadow nibbles i..DIGITS-1 are all zero.
- Digit 0 is never suppressed.

**Digit dark condition**
- A digit is dark if any of these hold:
  - blank_mask[i],
  - blink_mask[i] and blink_phase,
  - suppressed by lz.
- While dark, `dig`, `seg` and `dp` all sit at their inactive levels for the whole slot.

**Output during a slot**
- Dead time (cnt < BLANK_CYC): all outputs inactive.
- Otherwise `dig` is active at bit idx only, `seg` = decode(shadow nibble idx), and `dp` = shadow dp[idx].

**Decode (a..g)**

| Nibble | Code | Nibble | Code |
|---|---|---|---|
| 0 | 7E | 8 | 7F |
| 1 | 30 | 9 | 7B |
| 2 | 6D | A | 77 |
| 3 | 79 | b | 1F |
| 4 | 33 | C | 4E |
| 5 | 5B | d | 3D |
| 6 | 5F | E | 4F |
| 7 | 70 | F | 47 |

- Codes are shown for active-high polarity.
- With the polarity parameter set to 0, `seg`/`dp` (or `dig`) are bitwise inverted.

## Timing

**Reset values**
- cnt = 0, idx = 0.
- Shadow registers, frame counter and blink_phase = 0.
- `frame_start` = 0.
- `dig`, `seg`, `dp` at their inactive levels:
  - active-high: dig = all 0, seg = 0000000, dp = 0;
  - active-low: dig = all 1, seg = 1111111, dp = 1.

**Registered outputs**
- All outputs are registered and reflect cnt/idx/shadow from the previous cycle (1-cycle latency).
- The first active cycle of slot k comes BLANK_CYC+1 cycles after cnt becomes 0 with idx = k.

**Frame and snapshot**
- A frame is DIGITS*SCAN_DIV cycles.
- `frame_start` is high for exactly one cycle per frame.
- The new snapshot is first visible in the digit-0 slot that follows.

**After reset**
- After reset release, the first frame displays shadow = 0.
- With lz_en shadowed as 0, that frame shows "0" on every digit.

**Reset mid-operation**
- rst low forces all outputs inactive immediately (asynchronous).
- Scanning restarts at idx 0, cnt 0.

**Degenerate parameters**
- BLANK_CYC = 0: no dead time.
- DIGITS = 1: idx stays 0 and a snapshot occurs every SCAN_DIV cycles.

## Test plan

Common parameters: DIGITS=4, SCAN_DIV=8, BLANK_CYC=2, BLINK_FRAMES=2, both polarities active-high unless stated.

1. Assert rst mid-slot 2 -> dig=0000, seg=0000000, dp=0 immediately. After release, the first lit digit is dig=0001, 3 cycles after release.
2. value=16'h1234, dp_in=4'b0100, settled before a snapshot -> per slot:
   - slot 0: dig=0001, seg=0110011 (4);
   - slot 1: dig=0010, seg=1111001 (3);
   - slot 2: dig=0100, seg=1101101 (2), dp=1;
   - slot 3: dig=1000, seg=0110000 (1).
   - In each slot: 2 dark cycles, then 6 lit cycles.
3. Change value to 16'hABCD during slot 1 -> 1,2,3,4 continue to be shown until `frame_start`. The next frame shows d,C,b,A (3D, 4E, 1F, 77).
4. lz_en=1, value=16'h0050 -> digits 3 and 2 dark; digit 1 seg=1011011; digit 0 seg=1111110. With value=16'h0000, only digit 0 is lit (showing 0).
5. blink_mask=0001 -> digit 0 lit in frames 0–1 and dark in frames 2–3, repeating. Other digits are unaffected.
6. SEG_ACTIVE_HIGH=0, DIG_ACTIVE_HIGH=0:
   - reset -> dig=1111, seg=1111111, dp=1;
   - value nibble 8 in slot 0 -> dig=1110, seg=0000000.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Time-multiplexed seven-segment scanner with frame snapshot, dead time,
// per-digit blank/blink, leading-zero suppression and selectable polarity.
module seg7_scan_ctrl #(
  parameter int unsigned DIGITS          = 4,
  parameter int unsigned SCAN_DIV        = 50000,
  parameter int unsigned BLANK_CYC       = 16,
  parameter int unsigned BLINK_FRAMES    = 64,
  parameter bit          SEG_ACTIVE_HIGH = 1'b1,
  parameter bit          DIG_ACTIVE_HIGH = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [4*DIGITS-1:0]   value,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_mask,
  input  logic [DIGITS-1:0]     blink_mask,
  input  logic                  lz_en,
  output logic [DIGITS-1:0]     dig,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic                  frame_start
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned FrmW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CntW-1:0]   CntMax   = CntW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]   IdxMax   = IdxW'(DIGITS - 1);
  localparam logic [FrmW-1:0]   FrmMax   = FrmW'(BLINK_FRAMES - 1);
  localparam logic [CntW-1:0]   BlankCnt = CntW'(BLANK_CYC);

  // Inactive output levels; XOR with these applies the selected polarity.
  localparam logic [DIGITS-1:0] DigOff = DIG_ACTIVE_HIGH ? '0 : '1;
  localparam logic [6:0]        SegOff = SEG_ACTIVE_HIGH ? 7'h00 : 7'h7f;
  localparam logic              DpOff  = ~SEG_ACTIVE_HIGH;

  // Hex to a..g (bit6 = a), active-high.
  function automatic logic [6:0] decode(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h7e;
      4'h1:    code = 7'h30;
      4'h2:    code = 7'h6d;
      4'h3:    code = 7'h79;
      4'h4:    code = 7'h33;
      4'h5:    code = 7'h5b;
      4'h6:    code = 7'h5f;
      4'h7:    code = 7'h70;
      4'h8:    code = 7'h7f;
      4'h9:    code = 7'h7b;
      4'ha:    code = 7'h77;
      4'hb:    code = 7'h1f;
      4'hc:    code = 7'h4e;
      4'hd:    code = 7'h3d;
      4'he:    code = 7'h4f;
      default: code = 7'h47;
    endcase
    return code;
  endfunction

  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [IdxW-1:0]     idx_q, idx_d;
  logic [FrmW-1:0]     frm_q, frm_d;
  logic                blink_q, blink_d;
  logic                snap;

  logic [4*DIGITS-1:0] val_s;
  logic [DIGITS-1:0]   dp_s, blank_s, blink_s;
  logic                lz_s;

  logic [DIGITS-1:0]   lz_sup;
  logic [DIGITS-1:0]   dig_d;
  logic [6:0]          seg_d;
  logic                dp_d;

  // Slot/digit counters, snapshot strobe and blink timebase.
  always_comb begin
    logic wrap;
    logic last_digit;
    wrap       = (cnt_q == CntMax);
    last_digit = (idx_q == IdxMax);
    snap       = wrap & last_digit;
    cnt_d      = wrap ? '0 : cnt_q + 1'b1;
    idx_d      = idx_q;
    if (wrap) begin
      idx_d = last_digit ? '0 : idx_q + 1'b1;
    end
    frm_d   = frm_q;
    blink_d = blink_q;
    if (snap) begin
      if (frm_q == FrmMax) begin
        frm_d   = '0;
        blink_d = ~blink_q;
      end else begin
        frm_d = frm_q + 1'b1;
      end
    end
  end

  // Counter and blink state registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q   <= '0;
      idx_q   <= '0;
      frm_q   <= '0;
      blink_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      frm_q   <= frm_d;
      blink_q <= blink_d;
    end
  end

  // Shadow copy of the inputs, taken once per frame so a frame never tears.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_s   <= '0;
      dp_s    <= '0;
      blank_s <= '0;
      blink_s <= '0;
      lz_s    <= 1'b0;
    end else if (snap) begin
      val_s   <= value;
      dp_s    <= dp_in;
      blank_s <= blank_mask;
      blink_s <= blink_mask;
      lz_s    <= lz_en;
    end
  end

  // Leading-zero suppression: walk down from the top digit while all nibbles are zero.
  always_comb begin
    logic zero_above;
    zero_above = 1'b1;
    lz_sup     = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      zero_above = zero_above & (val_s[4*i +: 4] == 4'h0);
      lz_sup[i]  = lz_s & zero_above & (i != 0);
    end
  end

  // Next output values for the current slot, with dead time and dark handling.
  always_comb begin
    logic [3:0]        nib;
    logic              cur_dark;
    logic              cur_dp;
    logic              lit;
    logic [DIGITS-1:0] onehot;
    nib      = 4'h0;
    cur_dark = 1'b1;
    cur_dp   = 1'b0;
    onehot   = '0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (idx_q == IdxW'(i)) begin
        nib       = val_s[4*i +: 4];
        cur_dark  = blank_s[i] | (blink_s[i] & blink_q) | lz_sup[i];
        cur_dp    = dp_s[i];
        onehot[i] = 1'b1;
      end
    end
    lit   = (cnt_q >= BlankCnt) & ~cur_dark;
    dig_d = lit ? (onehot ^ DigOff) : DigOff;
    seg_d = lit ? (decode(nib) ^ SegOff) : SegOff;
    dp_d  = lit ? (cur_dp ^ DpOff) : DpOff;
  end

  // Registered outputs; reset drives the inactive levels asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dig         <= DigOff;
      seg         <= SegOff;
      dp          <= DpOff;
      frame_start <= 1'b0;
    end else begin
      dig         <= dig_d;
      seg         <= seg_d;
      dp          <= dp_d;
      frame_start <= snap;
    end
  end

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench: stimulus pushes one expected record per scan slot, a monitor
// rebuilds each slot from the pins and compares. Two DUTs run in lockstep, one
// active-high and one active-low; the active-low one is normalised before compare.
module tb_seg7_scan_ctrl;

  typedef struct packed {
    logic [3:0] dig;
    logic [6:0] seg;
    logic       dp;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] value = '0;
  logic [3:0]  dp_in = '0;
  logic [3:0]  blank_mask = '0;
  logic [3:0]  blink_mask = '0;
  logic        lz_en = 1'b0;

  logic [3:0]  dig0, dig1;
  logic [6:0]  seg0, seg1;
  logic        dp0, dp1, fs0, fs1;

  int checks = 0;
  int failures = 0;

  rec_t q0[$];
  rec_t q1[$];

  always #5 clk = ~clk;

  seg7_scan_ctrl #(
    .DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2),
    .SEG_ACTIVE_HIGH(1'b1), .DIG_ACTIVE_HIGH(1'b1)
  ) dut_hi (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .lz_en(lz_en), .dig(dig0), .seg(seg0), .dp(dp0),
    .frame_start(fs0)
  );

  seg7_scan_ctrl #(
    .DIGITS(4), .SCAN_DIV(8), .BLANK_CYC(2), .BLINK_FRAMES(2),
    .SEG_ACTIVE_HIGH(1'b0), .DIG_ACTIVE_HIGH(1'b0)
  ) dut_lo (
    .clk(clk), .rst(rst), .value(value), .dp_in(dp_in), .blank_mask(blank_mask),
    .blink_mask(blink_mask), .lz_en(lz_en), .dig(dig1), .seg(seg1), .dp(dp1),
    .frame_start(fs1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Expected record for slot k: lit digits show seg/dp, dark ones all inactive.
  task automatic push_slot(input int k, input logic lit, input logic [6:0] s, input logic d);
    rec_t r;
    r.dig = lit ? 4'(1 << k) : 4'b0000;
    r.seg = lit ? s : 7'h00;
    r.dp  = lit ? d : 1'b0;
    q0.push_back(r);
    q1.push_back(r);
  endtask

  task automatic push_frame(input logic [3:0] lit, input logic [6:0] s0, input logic [6:0] s1,
                            input logic [6:0] s2, input logic [6:0] s3, input logic [3:0] d);
    push_slot(0, lit[0], s0, d[0]);
    push_slot(1, lit[1], s1, d[1]);
    push_slot(2, lit[2], s2, d[2]);
    push_slot(3, lit[3], s3, d[3]);
  endtask

  task automatic wait_neg(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Monitor: s_m tracks which frame cycle the outputs currently show (0..31).
  int   s_m [2];
  int   slot_no [2];
  logic dead_ok [2];
  logic steady_ok [2];
  logic fs_ok [2];
  rec_t smp [2];

  always @(negedge clk) begin
    for (int n = 0; n < 2; n++) begin
      rec_t cur;
      rec_t want;
      logic fs;
      int   c;
      if (n == 0) begin
        cur = {dig0, seg0, dp0};
        fs  = fs0;
      end else begin
        cur = {~dig1, ~seg1, ~dp1};
        fs  = fs1;
      end
      if (!rst) begin
        s_m[n] = 31;
      end else begin
        s_m[n] = (s_m[n] + 1) % 32;
        c = s_m[n] % 8;
        if (c == 0) begin
          dead_ok[n]   = 1'b1;
          steady_ok[n] = 1'b1;
          fs_ok[n]     = 1'b1;
        end
        if (c < 2) begin
          dead_ok[n] = dead_ok[n] & (cur == '0);
        end else if (c == 2) begin
          smp[n] = cur;
        end else begin
          steady_ok[n] = steady_ok[n] & (cur == smp[n]);
        end
        fs_ok[n] = fs_ok[n] & (fs == (s_m[n] == 31));
        if (c == 7) begin
          checks++;
          slot_no[n]++;
          if ((n == 0 && q0.size() == 0) || (n == 1 && q1.size() == 0)) begin
            failures++;
            $display("FAIL dut%0d slot#%0d: output slot with no expected record", n, slot_no[n]);
          end else begin
            want = (n == 0) ? q0.pop_front() : q1.pop_front();
            if (smp[n] !== want || !dead_ok[n] || !steady_ok[n] || !fs_ok[n]) begin
              failures++;
              $display("FAIL dut%0d slot#%0d: got dig=%b seg=%b dp=%b dead_ok=%0d steady_ok=%0d fs_ok=%0d, want dig=%b seg=%b dp=%b dead_ok=1 steady_ok=1 fs_ok=1",
                       n, slot_no[n], smp[n].dig, smp[n].seg, smp[n].dp, dead_ok[n],
                       steady_ok[n], fs_ok[n], want.dig, want.seg, want.dp);
            end
          end
        end
      end
    end
  end

  initial begin
    for (int n = 0; n < 2; n++) begin
      s_m[n] = 31;
      slot_no[n] = 0;
    end
    wait_neg(3);
    check("reset dig_hi", 32'(dig0), 32'h0);
    check("reset seg_hi", 32'(seg0), 32'h00);
    check("reset dp_hi", 32'(dp0), 32'h0);
    check("reset frame_start", 32'(fs0), 32'h0);
    check("reset dig_lo", 32'(dig1), 32'hf);
    check("reset seg_lo", 32'(seg1), 32'h7f);
    check("reset dp_lo", 32'(dp1), 32'h1);
    #1 rst = 1'b1;

    // F0: shadow still zero, lz off -> "0" on every digit.
    push_frame(4'b1111, 7'h7e, 7'h7e, 7'h7e, 7'h7e, 4'b0000);
    value = 16'h1234;
    dp_in = 4'b0100;
    wait_neg(32);
    // F1: 4,3,2,1 with dp on digit 2.
    push_frame(4'b1111, 7'h33, 7'h79, 7'h6d, 7'h30, 4'b0100);
    wait_neg(32);
    // F2: value changes mid-frame; display holds 1234 until the next snapshot.
    push_frame(4'b1111, 7'h33, 7'h79, 7'h6d, 7'h30, 4'b0100);
    wait_neg(12);
    value = 16'habcd;
    wait_neg(20);
    // F3: d,C,b,A.
    push_frame(4'b1111, 7'h3d, 7'h4e, 7'h1f, 7'h77, 4'b0100);
    lz_en = 1'b1;
    value = 16'h0050;
    dp_in = 4'b0000;
    wait_neg(32);
    // F4: lz on 0050 -> digits 3,2 dark.
    push_frame(4'b0011, 7'h7e, 7'h5b, 7'h00, 7'h00, 4'b0000);
    value = 16'h0000;
    wait_neg(32);
    // F5: lz on 0000 -> only digit 0.
    push_frame(4'b0001, 7'h7e, 7'h00, 7'h00, 7'h00, 4'b0000);
    lz_en = 1'b0;
    value = 16'h1234;
    blink_mask = 4'b0001;
    wait_neg(32);
    // F6, F7: blink off phase, digit 0 dark.
    push_frame(4'b1110, 7'h00, 7'h79, 7'h6d, 7'h30, 4'b0000);
    wait_neg(32);
    push_frame(4'b1110, 7'h00, 7'h79, 7'h6d, 7'h30, 4'b0000);
    wait_neg(32);
    // F8, F9: blink on phase.
    push_frame(4'b1111, 7'h33, 7'h79, 7'h6d, 7'h30, 4'b0000);
    wait_neg(32);
    push_frame(4'b1111, 7'h33, 7'h79, 7'h6d, 7'h30, 4'b0000);
    blank_mask = 4'b0100;
    wait_neg(32);
    // F10: blink off plus digit 2 blanked.
    push_frame(4'b1010, 7'h00, 7'h79, 7'h00, 7'h30, 4'b0000);
    blank_mask = 4'b0000;
    wait_neg(32);
    // F11: reset lands inside the lit part of slot 2.
    push_slot(0, 1'b0, 7'h00, 1'b0);
    push_slot(1, 1'b1, 7'h79, 1'b0);
    wait_neg(19);
    check("pre-reset dig_hi slot2", 32'(dig0), 32'h4);
    #3 rst = 1'b0;
    #1;
    check("async reset dig_hi", 32'(dig0), 32'h0);
    check("async reset seg_hi", 32'(seg0), 32'h00);
    check("async reset dp_hi", 32'(dp0), 32'h0);
    check("async reset dig_lo", 32'(dig1), 32'hf);
    check("async reset seg_lo", 32'(seg1), 32'h7f);
    q0.delete();
    q1.delete();
    value = 16'h1238;
    dp_in = 4'b0001;
    blink_mask = 4'b0000;
    wait_neg(2);
    #1 rst = 1'b1;
    // G0: restart from idx 0 with zero shadow.
    push_frame(4'b1111, 7'h7e, 7'h7e, 7'h7e, 7'h7e, 4'b0000);
    wait_neg(32);
    // G1: 8 with dp in slot 0, then 3,2,1.
    push_frame(4'b1111, 7'h7f, 7'h79, 7'h6d, 7'h30, 4'b0001);
    wait_neg(4);
    check("active-low dig slot0 nib8", 32'(dig1), 32'he);
    check("active-low seg slot0 nib8", 32'(seg1), 32'h00);
    check("active-low dp slot0", 32'(dp1), 32'h0);
    wait_neg(28);
    #1;
    check("scoreboard drained hi", 32'(q0.size()), 32'h0);
    check("scoreboard drained lo", 32'(q1.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
